mem_req_arbiter: RTL and testbench

// - Shares the single line-fill memory port (mem_sim: mem_req/mem_addr/mem_data_in/mem_ready) among NUM_REQ requesters
//   (I-cache miss handler, prefetcher, ...).
// - Round-robin grant; one outstanding memory transaction at a time.
// - Holds mem_req/mem_addr stable until mem_ready, then routes the 128-bit line back to the winning requester.

---
 rtl/mem_req_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one line-fill memory port among NUM_REQ requesters, one transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to abort a transaction with resp_err after TIMEOUT_CYC cycles without mem_ready.
module mem_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [LINE_W-1:0]         resp_data,
  output logic [NUM_REQ-1:0]        resp_err,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [LINE_W-1:0]         mem_data_in,
  input  logic                      mem_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mem_req_arbiter: unsupported parameter set");
  end

  logic [1:0]       state;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             pick_found;
  logic             timeout_hit;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Fires in the last allowed REQ cycle; a mem_ready in that same cycle still completes normally.
  assign timeout_hit = (state == ST_REQ) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      rr_ptr     <= '0;
      req_ack    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      resp_err   <= '0;
      wait_cnt   <= '0;
`endif
    end else begin
      req_ack    <= '0;
      resp_valid <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      resp_err   <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt      <= pick_idx;
            rr_ptr   <= next_ptr;
            mem_req  <= 1'b1;
            mem_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            req_ack  <= ONE << pick_idx;
            state    <= ST_REQ;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            resp_data  <= mem_data_in;
            resp_valid <= ONE << gnt;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            state      <= ST_RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            resp_err <= ONE << gnt;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(req_ack) && $onehot0(resp_valid) && $onehot0(resp_err) && ((resp_valid & resp_err) == '0));

  a_mem_hold: assert property (@(posedge clk) disable iff (!rst)
    (mem_req && !mem_ready && !timeout_hit) |=> (mem_req && $stable(mem_addr)));

  a_addr_idle: assert property (@(posedge clk) disable iff (!rst)
    !mem_req |-> (mem_addr == '0));

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 128;

  localparam logic [LW-1:0] D_A5 = {16{8'hA5}};
  localparam logic [LW-1:0] D_B7 = {16{8'hB7}};
  localparam logic [LW-1:0] D_CC = {16{8'hCC}};
  localparam logic [LW-1:0] D_DD = {16{8'hDD}};
  localparam logic [LW-1:0] D_EE = {16{8'hEE}};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  resp_valid;
  logic [LW-1:0] resp_data;
  logic [N-1:0]  resp_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_data_in;
  logic          mem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  mem_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ack     (req_ack),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_ready   (mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [N-1:0]  valid;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          ready;
    logic [LW-1:0] data;
    logic [N-1:0]  ack;
    logic          mreq;
    logic [AW-1:0] maddr;
    logic [N-1:0]  rv;
    logic [LW-1:0] rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Outputs are sampled on the falling edge, then inputs for the next rising edge are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    mem_ready   = 1'b0;
    mem_data_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int acks[$];
    int last_ack;
    int ones;
    int seen;

    // ---------------- reset state ----------------
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ack", LW'(req_ack), '0);
    check("reset resp_valid", LW'(resp_valid), '0);
    check("reset resp_err", LW'(resp_err), '0);
    check("reset mem_req", LW'(mem_req), '0);
    check("reset mem_addr", LW'(mem_addr), '0);
    check("reset resp_data", resp_data, '0);
    rst = 1'b1;

    // ---------------- vector table ----------------
    tbl[0]  = '{2'b01, 32'h00FF_7A10, 32'h0, 1'b0, '0,   2'b01, 1'b1, 32'h00FF_7A10, 2'b00, '0};
    tbl[1]  = '{2'b00, 32'h00FF_7A10, 32'h0, 1'b0, '0,   2'b00, 1'b1, 32'h00FF_7A10, 2'b00, '0};
    tbl[2]  = '{2'b00, 32'h00FF_7A10, 32'h0, 1'b1, D_A5, 2'b00, 1'b0, 32'h0,         2'b01, D_A5};
    tbl[3]  = '{2'b11, 32'h1000,      32'h2000, 1'b0, '0,   2'b00, 1'b0, 32'h0,      2'b00, D_A5};
    tbl[4]  = '{2'b11, 32'h1000,      32'h2000, 1'b0, '0,   2'b10, 1'b1, 32'h2000,   2'b00, D_A5};
    tbl[5]  = '{2'b01, 32'h1000,      32'h2000, 1'b1, D_B7, 2'b00, 1'b0, 32'h0,      2'b10, D_B7};
    tbl[6]  = '{2'b01, 32'h1000,      32'h2000, 1'b1, D_CC, 2'b00, 1'b0, 32'h0,      2'b00, D_B7};
    tbl[7]  = '{2'b01, 32'h1000,      32'h2000, 1'b1, D_DD, 2'b01, 1'b1, 32'h1000,   2'b00, D_B7};
    tbl[8]  = '{2'b00, 32'h1000,      32'h2000, 1'b0, '0,   2'b00, 1'b1, 32'h1000,   2'b00, D_B7};
    tbl[9]  = '{2'b00, 32'h1000,      32'h2000, 1'b1, D_EE, 2'b00, 1'b0, 32'h0,      2'b01, D_EE};
    tbl[10] = '{2'b00, 32'h1000,      32'h2000, 1'b0, '0,   2'b00, 1'b0, 32'h0,      2'b00, D_EE};

    do_reset();
    for (int k = 0; k < 11; k++) begin
      req_valid   = tbl[k].valid;
      req_addr    = {tbl[k].a1, tbl[k].a0};
      mem_ready   = tbl[k].ready;
      mem_data_in = tbl[k].data;
      tick();
      check($sformatf("vec%0d req_ack", k), LW'(req_ack), LW'(tbl[k].ack));
      check($sformatf("vec%0d mem_req", k), LW'(mem_req), LW'(tbl[k].mreq));
      check($sformatf("vec%0d mem_addr", k), LW'(mem_addr), LW'(tbl[k].maddr));
      check($sformatf("vec%0d resp_valid", k), LW'(resp_valid), LW'(tbl[k].rv));
      check($sformatf("vec%0d resp_data", k), resp_data, tbl[k].rdata);
    end

    // ---------------- tie after reset + fairness ----------------
    do_reset();
    req_addr  = {32'h2000_0000, 32'h1000_0000};
    req_valid = 2'b11;
    last_ack  = -1;
    for (int c = 0; c < 200 && acks.size() < 8; c++) begin
      tick();
      mem_ready   = mem_req;
      mem_data_in = LW'(c);
      if (req_ack != '0) begin
        acks.push_back(req_ack == 2'b10 ? 1 : 0);
        if (last_ack >= 0) check("fair ack spacing", LW'(c - last_ack), LW'(3));
        last_ack = c;
      end
    end
    check("fair ack count", LW'(acks.size()), LW'(8));
    ones = 0;
    for (int i = 0; i < acks.size(); i++) begin
      check($sformatf("fair grant %0d", i), LW'(acks[i]), LW'(i % 2));
      ones += acks[i];
    end
    check("fair req1 acks", LW'(ones), LW'(4));

    // ---------------- slow memory ----------------
    do_reset();
    req_addr  = {32'h0, 32'hCAFE_0040};
    req_valid = 2'b01;
    tick();
    check("slow req_ack", LW'(req_ack), LW'(2'b01));
    req_valid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("slow mem_req c%0d", c), LW'(mem_req), LW'(1'b1));
      check($sformatf("slow mem_addr c%0d", c), LW'(mem_addr), LW'(32'hCAFE_0040));
      check($sformatf("slow resp_valid c%0d", c), LW'(resp_valid), '0);
    end
    mem_ready   = 1'b1;
    mem_data_in = D_DD;
    tick();
    mem_ready = 1'b0;
    check("slow resp_valid", LW'(resp_valid), LW'(2'b01));
    check("slow resp_data", resp_data, D_DD);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (resp_valid != '0) seen++;
    end
    check("slow extra resp pulses", LW'(seen), '0);

    // ---------------- reset mid-REQ ----------------
    do_reset();
    req_addr  = {32'h0, 32'h0000_3000};
    req_valid = 2'b01;
    tick();
    check("rstmid req_ack", LW'(req_ack), LW'(2'b01));
    req_valid = 2'b00;
    tick();
    check("rstmid mem_req before", LW'(mem_req), LW'(1'b1));
    #2 rst = 1'b0;
    #1;
    check("rstmid mem_req async", LW'(mem_req), '0);
    check("rstmid mem_addr async", LW'(mem_addr), '0);
    @(negedge clk);
    rst       = 1'b1;
    req_addr  = {32'h0000_5000, 32'h0000_4000};
    req_valid = 2'b11;
    tick();
    check("rstmid fresh tie ack", LW'(req_ack), LW'(2'b01));
    check("rstmid fresh addr", LW'(mem_addr), LW'(32'h0000_4000));
    check("rstmid no stale resp", LW'(resp_valid), '0);

`ifdef MEM_ARB_TIMEOUT_EN
    // ---------------- timeout ----------------
    do_reset();
    req_addr  = {32'h0000_B000, 32'h0000_A000};
    req_valid = 2'b11;
    tick();
    check("tmo first ack", LW'(req_ack), LW'(2'b01));
    req_valid = 2'b10;
    seen = -1;
    for (int k = 1; k <= 100 && seen < 0; k++) begin
      tick();
      check($sformatf("tmo no resp_valid k%0d", k), LW'(resp_valid), '0);
      if (resp_err != '0) seen = k;
    end
    check("tmo err latency", LW'(seen), LW'(64));
    check("tmo err bit", LW'(resp_err), LW'(2'b01));
    check("tmo mem_req dropped", LW'(mem_req), '0);
    tick();
    check("tmo next grant", LW'(req_ack), LW'(2'b10));
    req_valid = 2'b00;
    for (int k = 0; k < 63; k++) tick();
    mem_ready   = 1'b1;
    mem_data_in = D_CC;
    tick();
    mem_ready = 1'b0;
    check("tmo late ready resp_valid", LW'(resp_valid), LW'(2'b10));
    check("tmo late ready no err", LW'(resp_err), '0);
    check("tmo late ready data", resp_data, D_CC);
`endif

    // ---------------- randomized vs reference model ----------------
    begin
      bit            port_free  = 1'b1;
      bit            awaiting   = 1'b0;
      bit            delivering = 1'b0;
      bit            old_free, old_await, old_deliv;
      int            rr_m  = 0;
      int            owner = 0;
      int            w;
      logic [AW-1:0] own_addr = '0;
      logic [LW-1:0] line_m   = '0;
      logic [N-1:0]  v_prev, exp_ack, exp_rv;
      logic [N*AW-1:0] a_prev;
      logic          r_prev;
      logic [LW-1:0] d_prev;

      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int i = 0; i < N; i++) begin
          if (req_ack[i]) begin
            req_valid[i] = 1'b0;
          end else if (!req_valid[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              req_valid[i]            = 1'b1;
              req_addr[i*AW +: AW]    = $urandom;
            end
          end else if ($urandom_range(0, 19) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        mem_ready   = ($urandom_range(0, 3) == 0);
        mem_data_in = {$urandom, $urandom, $urandom, $urandom};
        v_prev = req_valid;
        a_prev = req_addr;
        r_prev = mem_ready;
        d_prev = mem_data_in;
        tick();

        // A free port grants the round-robin winner; the owner's transaction ends on mem_ready,
        // its response is delivered for one cycle and the port is free again after that.
        exp_ack   = '0;
        exp_rv    = '0;
        old_free  = port_free;
        old_await = awaiting;
        old_deliv = delivering;
        if (old_free && v_prev != '0) begin
          w          = rr_pick(v_prev, rr_m);
          exp_ack[w] = 1'b1;
          rr_m       = (w + 1) % N;
          owner      = w;
          own_addr   = a_prev[w*AW +: AW];
          port_free  = 1'b0;
          awaiting   = 1'b1;
        end
        if (old_await && r_prev) begin
          line_m        = d_prev;
          exp_rv[owner] = 1'b1;
          awaiting      = 1'b0;
          delivering    = 1'b1;
        end
        if (old_deliv) begin
          delivering = 1'b0;
          port_free  = 1'b1;
        end

        check($sformatf("rnd%0d req_ack", cyc), LW'(req_ack), LW'(exp_ack));
        check($sformatf("rnd%0d resp_valid", cyc), LW'(resp_valid), LW'(exp_rv));
        check($sformatf("rnd%0d resp_err", cyc), LW'(resp_err), '0);
        check($sformatf("rnd%0d mem_req", cyc), LW'(mem_req), LW'(awaiting));
        check($sformatf("rnd%0d mem_addr", cyc), LW'(mem_addr), awaiting ? LW'(own_addr) : '0);
        check($sformatf("rnd%0d resp_data", cyc), resp_data, line_m);
      end
      req_valid = '0;
      mem_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
